// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for the JK flip-flop with preset/clear: queues control commands,
// drives J/K/preset/clr for a programmed number of cycles and checks q/qbar against a model.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_len,
  output logic                     j,
  output logic                     k,
  output logic                     preset,
  output logic                     clr,
  input  logic                     q_in,
  input  logic                     qbar_in,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     exp_q,
  input  logic                     err_clr,
  output logic                     err_mismatch,
  output logic                     err_illegal
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t           state;
  logic [2:0]       op_mem  [DEPTH];
  logic [CNT_W-1:0] len_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             exp_q_d;
  logic [1:0]       chk_vld;

  logic             push;
  logic             pop;
  logic             empty;
  logic             illegal_head;
  logic [3:0]       head_drv;
  logic [3:0]       next_drv;
  logic             next_active;
  logic             next_exp_q;
  logic             mismatch_evt;
  logic             illegal_evt;

  assign empty        = (level == '0);
  assign cmd_ready    = (level != (AW+1)'(DEPTH));
  assign push         = cmd_valid && cmd_ready;
  assign pop          = !empty && ((state == IDLE) || (cnt == '0));
  assign illegal_head = (op_mem[rd_ptr] > 3'd5);
  assign illegal_evt  = pop && illegal_head;
  assign mismatch_evt = chk_vld[1] && ((q_in != exp_q_d) || (q_in == qbar_in));

  // Drive pattern {j,k,preset,clr} of the command at the FIFO head; illegal ops hold.
  always_comb begin
    head_drv = 4'b0000;
    case (op_mem[rd_ptr])
      3'd1:    head_drv = 4'b0100;
      3'd2:    head_drv = 4'b1000;
      3'd3:    head_drv = 4'b1100;
      3'd4:    head_drv = 4'b0001;
      3'd5:    head_drv = 4'b0010;
      default: head_drv = 4'b0000;
    endcase
  end

  always_comb begin
    next_drv    = 4'b0000;
    next_active = 1'b0;
    if (pop) begin
      next_drv    = head_drv;
      next_active = 1'b1;
    end else if (state == DRIVE && cnt != '0) begin
      next_drv    = {j, k, preset, clr};
      next_active = 1'b1;
    end
  end

  // exp_q tracks what the flip-flop will hold once the drives being registered take effect.
  always_comb begin
    next_exp_q = exp_q;
    if (next_active) begin
      if (next_drv[0])
        next_exp_q = 1'b0;
      else if (next_drv[1])
        next_exp_q = 1'b1;
      else if (next_drv[3] && next_drv[2])
        next_exp_q = ~exp_q;
      else if (next_drv[3])
        next_exp_q = 1'b1;
      else if (next_drv[2])
        next_exp_q = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        op_mem[wr_ptr]  <= cmd_op;
        len_mem[wr_ptr] <= cmd_len;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        level <= level + (AW+1)'(1);
      else if (pop && !push)
        level <= level - (AW+1)'(1);
    end
  end

  // clr is held high through reset so the flip-flop starts from a known 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      j      <= 1'b0;
      k      <= 1'b0;
      preset <= 1'b0;
      clr    <= 1'b1;
      busy   <= 1'b0;
      exp_q  <= 1'b0;
    end else begin
      {j, k, preset, clr} <= next_drv;
      busy                <= next_active;
      exp_q               <= next_exp_q;
      if (pop) begin
        state <= DRIVE;
        cnt   <= illegal_head ? '0 : len_mem[rd_ptr];
      end else if (state == DRIVE && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        state <= IDLE;
      end
    end
  end

  // An error event on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_q_d      <= 1'b0;
      chk_vld      <= 2'b00;
      err_mismatch <= 1'b0;
      err_illegal  <= 1'b0;
    end else begin
      exp_q_d      <= exp_q;
      chk_vld      <= {chk_vld[0], 1'b1};
      err_mismatch <= (err_mismatch && !err_clr) || mismatch_evt;
      err_illegal  <= (err_illegal && !err_clr) || illegal_evt;
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: ideal JK flip-flop, queue-based reference model,
// per-cycle compare plus directed literal checks.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic             j, k, preset, clr;
  logic             q_in, qbar_in;
  logic             busy;
  logic [2:0]       level;
  logic             exp_q;
  logic             err_clr;
  logic             err_mismatch;
  logic             err_illegal;

  int checks = 0;
  int errors = 0;

  logic ff_q     = 1'b0;
  logic fault_en = 1'b0;
  logic fq       = 1'b0;
  logic fqb      = 1'b1;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .j(j), .k(k), .preset(preset), .clr(clr),
    .q_in(q_in), .qbar_in(qbar_in),
    .busy(busy), .level(level), .exp_q(exp_q),
    .err_clr(err_clr), .err_mismatch(err_mismatch), .err_illegal(err_illegal)
  );

  // Ideal flip-flop; fault_en overrides what the sequencer sees on its feedback pins.
  assign q_in    = fault_en ? fq  : ff_q;
  assign qbar_in = fault_en ? fqb : ~ff_q;

  always @(posedge clk) begin
    if (clr)              ff_q <= 1'b0;
    else if (preset)      ff_q <= 1'b1;
    else if (j && k)      ff_q <= ~ff_q;
    else if (j)           ff_q <= 1'b1;
    else if (k)           ff_q <= 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: command queue plus remaining-cycle count of the active command.
  typedef struct {
    logic [2:0] op;
    logic [3:0] len;
  } cmd_t;

  cmd_t mq[$];
  bit   model_ok = 0;
  bit   m_busy;
  int   m_rem;
  logic [3:0] m_drv;
  logic m_expq, m_expq_p, m_mis, m_ill;
  int   since;

  function automatic logic [3:0] opDrive(input logic [2:0] op);
    case (op)
      3'd1:    return 4'b0100;
      3'd2:    return 4'b1000;
      3'd3:    return 4'b1100;
      3'd4:    return 4'b0001;
      3'd5:    return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clk) begin
    cmd_t c;
    int   qsz;
    bit   do_push, mis_evt, ill_evt;
    if (!rst_n) begin
      mq.delete();
      m_busy = 0; m_rem = 0; m_drv = 4'b0001;
      m_expq = 0; m_expq_p = 0; m_mis = 0; m_ill = 0;
      since = 0; model_ok = 1;
    end else begin
      mis_evt = (since >= 2) && ((q_in !== m_expq_p) || (q_in === qbar_in));
      ill_evt = 0;
      qsz     = mq.size();
      do_push = cmd_valid && (qsz < DEPTH);
      if (m_busy && m_rem > 1) begin
        m_rem--;
      end else if (qsz > 0) begin
        c = mq.pop_front();
        m_busy = 1;
        if (c.op > 3'd5) begin
          ill_evt = 1; m_rem = 1; m_drv = 4'b0000;
        end else begin
          m_rem = int'(c.len) + 1; m_drv = opDrive(c.op);
        end
      end else begin
        m_busy = 0; m_rem = 0; m_drv = 4'b0000;
      end
      if (do_push) begin
        c.op = cmd_op; c.len = cmd_len;
        mq.push_back(c);
      end
      m_expq_p = m_expq;
      if (m_busy) begin
        if (m_drv[0])                m_expq = 0;
        else if (m_drv[1])           m_expq = 1;
        else if (m_drv[3] && m_drv[2]) m_expq = ~m_expq;
        else if (m_drv[3])           m_expq = 1;
        else if (m_drv[2])           m_expq = 0;
      end
      m_mis = (m_mis && !err_clr) || mis_evt;
      m_ill = (m_ill && !err_clr) || ill_evt;
      if (since < 3) since++;
    end
  end

  always @(posedge clk) begin
    #2;
    if (model_ok) begin
      checkOutput("cyc_j",        32'(j),            32'(m_drv[3]));
      checkOutput("cyc_k",        32'(k),            32'(m_drv[2]));
      checkOutput("cyc_preset",   32'(preset),       32'(m_drv[1]));
      checkOutput("cyc_clr",      32'(clr),          32'(m_drv[0]));
      checkOutput("cyc_busy",     32'(busy),         32'(m_busy));
      checkOutput("cyc_level",    32'(level),        32'(mq.size()));
      checkOutput("cyc_ready",    32'(cmd_ready),    32'(mq.size() < DEPTH));
      checkOutput("cyc_exp_q",    32'(exp_q),        32'(m_expq));
      checkOutput("cyc_err_mis",  32'(err_mismatch), 32'(m_mis));
      checkOutput("cyc_err_ill",  32'(err_illegal),  32'(m_ill));
      if (since >= 2)
        checkOutput("model_vs_ff", 32'(ff_q), 32'(m_expq_p));
    end
  end

  int busy_cycles = 0;
  always @(negedge clk) if (busy === 1'b1) busy_cycles++;

  // Called at a negedge; holds the command until it is accepted, returns at the following negedge.
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] len);
    int w = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len;
    while (cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++; errors++;
      $display("[TB] FAIL push_timeout got cmd_ready=%b expected 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int w = 0;
    while ((busy !== 1'b0 || level !== 3'd0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 100) begin
      errors++;
      $display("[TB] FAIL idle_timeout got busy=%b level=%0d expected 0/0", busy, level);
    end
  endtask

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int b0;
    int drv_seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; err_clr = 1'b0;

    $display("[TB] reset");
    repeat (3) @(negedge clk);
    checkOutput("rst_clr",   32'(clr),          1);
    checkOutput("rst_j",     32'(j),            0);
    checkOutput("rst_k",     32'(k),            0);
    checkOutput("rst_pre",   32'(preset),       0);
    checkOutput("rst_ready", 32'(cmd_ready),    1);
    checkOutput("rst_level", 32'(level),        0);
    checkOutput("rst_expq",  32'(exp_q),        0);
    checkOutput("rst_emis",  32'(err_mismatch), 0);
    checkOutput("rst_eill",  32'(err_illegal),  0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_clr", 32'(clr), 0);
    repeat (50) @(negedge clk);
    checkOutput("idle_emis", 32'(err_mismatch), 0);

    $display("[TB] toggle len=2");
    applyStimulus(3'd3, 4'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("tog_j",    32'(j),    1);
      checkOutput("tog_k",    32'(k),    1);
      checkOutput("tog_busy", 32'(busy), 1);
    end
    @(negedge clk);
    checkOutput("tog_end_j",    32'(j),     0);
    checkOutput("tog_end_busy", 32'(busy),  0);
    checkOutput("tog_expq",     32'(exp_q), 1);
    checkOutput("tog_ffq",      32'(ff_q),  1);
    repeat (3) @(negedge clk);
    checkOutput("tog_emis", 32'(err_mismatch), 0);

    $display("[TB] backpressure");
    b0 = busy_cycles;
    applyStimulus(3'd3, 4'd15);
    applyStimulus(3'd2, 4'd0);
    applyStimulus(3'd1, 4'd0);
    applyStimulus(3'd2, 4'd0);
    applyStimulus(3'd2, 4'd0);
    checkOutput("bp_level", 32'(level),     4);
    checkOutput("bp_ready", 32'(cmd_ready), 0);
    applyStimulus(3'd1, 4'd0);
    waitIdle();
    checkOutput("bp_busy_cycles", 32'(busy_cycles - b0), 21);
    checkOutput("bp_expq",        32'(exp_q),            0);
    checkOutput("bp_ffq",         32'(ff_q),             0);

    $display("[TB] illegal op");
    applyStimulus(3'd7, 4'd0);
    applyStimulus(3'd2, 4'd0);
    checkOutput("ill_flag", 32'(err_illegal), 1);
    checkOutput("ill_busy", 32'(busy),        1);
    checkOutput("ill_hold", 32'({j, k, preset, clr}), 0);
    @(negedge clk);
    checkOutput("ill_set_j", 32'(j), 1);
    @(negedge clk);
    checkOutput("ill_done_j",    32'(j),    0);
    checkOutput("ill_done_busy", 32'(busy), 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("ill_cleared", 32'(err_illegal), 0);

    $display("[TB] fault injection");
    applyStimulus(3'd4, 4'd0);
    waitIdle();
    repeat (3) @(negedge clk);
    applyStimulus(3'd5, 4'd0);
    @(negedge clk);
    checkOutput("flt_preset", 32'(preset), 1);
    fault_en = 1'b1; fq = 1'b0; fqb = 1'b1;
    @(negedge clk);
    checkOutput("flt_d1", 32'(err_mismatch), 0);
    @(negedge clk);
    checkOutput("flt_d2", 32'(err_mismatch), 1);
    fault_en = 1'b0;
    err_clr  = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("flt_cleared", 32'(err_mismatch), 0);
    fault_en = 1'b1; fq = 1'b1; fqb = 1'b1;
    @(negedge clk);
    checkOutput("flt_qeq", 32'(err_mismatch), 1);
    err_clr = 1'b1;
    @(negedge clk);
    checkOutput("flt_clr_vs_evt", 32'(err_mismatch), 1);
    fault_en = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("flt_cleared2", 32'(err_mismatch), 0);

    $display("[TB] reset mid-operation");
    applyStimulus(3'd3, 4'd10);
    applyStimulus(3'd2, 4'd0);
    applyStimulus(3'd1, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy",  32'(busy),      0);
    checkOutput("mid_clr",   32'(clr),       1);
    checkOutput("mid_level", 32'(level),     0);
    checkOutput("mid_ready", 32'(cmd_ready), 1);
    rst_n = 1'b1;
    drv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (j || k || preset) drv_seen++;
    end
    checkOutput("mid_no_drive", 32'(drv_seen),     0);
    checkOutput("mid_emis",     32'(err_mismatch), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
